// File: rtl/rgen_pkg.sv
// Shared types, status codes and the mask-to-strobe reduction for the rgen APB initiator.
package rgen_pkg;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_SETUP    = 2'd1,
    ST_ACCESS   = 2'd2,
    ST_RESPONSE = 2'd3
  } state_e;

  localparam logic [1:0] STATUS_OK      = 2'b00;
  localparam logic [1:0] STATUS_SLVERR  = 2'b10;
  localparam logic [1:0] STATUS_TIMEOUT = 2'b11;

  // Bit 'b' of the result is set when any bit of mask byte 'b' is set; sized for the widest bus.
  function automatic logic [7:0] mask_to_strb(input logic [63:0] mask);
    logic [7:0] strb;
    strb = '0;
    for (int b = 0; b < 8; b++) begin
      strb[b] = |mask[8*b +: 8];
    end
    return strb;
  endfunction

endpackage

// File: rtl/rgen_apb_initiator_if.sv
// rgen command/response interface; the host drives commands (master), the initiator serves them (slave).
interface rgen_apb_initiator_if #(
  parameter int DATA_WIDTH    = 32,
  parameter int ADDRESS_WIDTH = 16
);
  logic                     command_valid;
  logic                     command_ready;
  logic                     write;
  logic [ADDRESS_WIDTH-1:0] address;
  logic [DATA_WIDTH-1:0]    write_data;
  logic [DATA_WIDTH-1:0]    write_mask;
  logic                     response_valid;
  logic                     response_ready;
  logic [DATA_WIDTH-1:0]    read_data;
  logic [1:0]               status;

  modport master (
    output command_valid, write, address, write_data, write_mask, response_ready,
    input  command_ready, response_valid, read_data, status
  );

  modport slave (
    input  command_valid, write, address, write_data, write_mask, response_ready,
    output command_ready, response_valid, read_data, status
  );
endinterface

// File: rtl/rgen_wait_counter.sv
// ACCESS-phase wait budget: loaded on entry to ACCESS, counts down per stalled cycle,
// expires once TIMEOUT_CYCLES-1 stalled cycles have elapsed.
module rgen_wait_counter #(
  parameter int TIMEOUT_CYCLES = 256
) (
  input  logic clk,
  input  logic rst,
  input  logic i_clear,
  input  logic i_step,
  output logic o_expire
);
  localparam int CNT_W = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;

  logic [CNT_W-1:0] r_remaining;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_remaining <= '0;
    end else if (i_clear) begin
      r_remaining <= CNT_W'(TIMEOUT_CYCLES - 1);
    end else if (i_step && (r_remaining != '0)) begin
      r_remaining <= r_remaining - 1'b1;
    end
  end

  assign o_expire = (r_remaining == '0);
endmodule

// File: rtl/rgen_apb_initiator.sv
// Bridges single-beat rgen commands onto an APB4 completer, one transfer in flight.
// Optional ACCESS timeout enabled by defining RGEN_APB_INITIATOR_TIMEOUT_EN.
//
// state     | meaning
// IDLE      | ready for a command; APB bus idle
// SETUP     | psel=1, penable=0 for one cycle
// ACCESS    | psel=1, penable=1 until pready (or timeout abort)
// RESPONSE  | response_valid=1, result held until response_ready
module rgen_apb_initiator
  import rgen_pkg::*;
#(
  parameter int         DATA_WIDTH     = 32,
  parameter int         ADDRESS_WIDTH  = 16,
  parameter logic [2:0] PPROT_VALUE    = 3'b000,
  parameter int         TIMEOUT_CYCLES = 256
) (
  input  logic                      clk,
  input  logic                      rst,
  rgen_apb_initiator_if.slave       io_rgen,
  output logic [ADDRESS_WIDTH-1:0]  o_paddr,
  output logic [2:0]                o_pprot,
  output logic                      o_psel,
  output logic                      o_penable,
  output logic                      o_pwrite,
  output logic [DATA_WIDTH-1:0]     o_pwdata,
  output logic [DATA_WIDTH/8-1:0]   o_pstrb,
  input  logic                      i_pready,
  input  logic [DATA_WIDTH-1:0]     i_prdata,
  input  logic                      i_pslverr
);
  localparam int STRB_W   = DATA_WIDTH / 8;
  localparam int ADDR_LSB = $clog2(STRB_W);
  localparam logic [ADDRESS_WIDTH-1:0] ADDR_MASK =
    ~((ADDRESS_WIDTH'(1) << ADDR_LSB) - ADDRESS_WIDTH'(1));

  localparam logic [1:0] S_IDLE     = ST_IDLE;
  localparam logic [1:0] S_SETUP    = ST_SETUP;
  localparam logic [1:0] S_ACCESS   = ST_ACCESS;
  localparam logic [1:0] S_RESPONSE = ST_RESPONSE;

  if (!(DATA_WIDTH == 8 || DATA_WIDTH == 16 || DATA_WIDTH == 32 || DATA_WIDTH == 64))
  begin : g_bad_data_width
    $error("rgen_apb_initiator: DATA_WIDTH must be 8, 16, 32 or 64");
  end
  if (TIMEOUT_CYCLES < 2) begin : g_bad_timeout
    $error("rgen_apb_initiator: TIMEOUT_CYCLES must be >= 2");
  end

  logic [1:0]               r_state;
  logic [ADDRESS_WIDTH-1:0] r_paddr;
  logic                     r_pwrite;
  logic [DATA_WIDTH-1:0]    r_pwdata;
  logic [STRB_W-1:0]        r_pstrb;
  logic [DATA_WIDTH-1:0]    r_read_data;
  logic [1:0]               r_status;

  logic [STRB_W-1:0]        w_strb;
  logic                     w_expired;

  assign w_strb = STRB_W'(mask_to_strb(64'(io_rgen.write_mask)));

`ifdef RGEN_APB_INITIATOR_TIMEOUT_EN
  rgen_wait_counter #(
    .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
  ) u_wait_counter (
    .clk      (clk),
    .rst      (rst),
    .i_clear  (r_state == S_SETUP),
    .i_step   ((r_state == S_ACCESS) && !i_pready),
    .o_expire (w_expired)
  );
`else
  assign w_expired = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_paddr     <= '0;
      r_pwrite    <= 1'b0;
      r_pwdata    <= '0;
      r_pstrb     <= '0;
      r_read_data <= '0;
      r_status    <= STATUS_OK;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (io_rgen.command_valid) begin
            r_paddr  <= io_rgen.address & ADDR_MASK;
            r_pwrite <= io_rgen.write;
            r_pwdata <= io_rgen.write_data;
            r_pstrb  <= io_rgen.write ? w_strb : '0;
            r_state  <= S_SETUP;
          end
        end
        S_SETUP: begin
          r_state <= S_ACCESS;
        end
        S_ACCESS: begin
          // Completion takes priority over a timeout expiring in the same cycle.
          if (i_pready) begin
            r_read_data <= (!r_pwrite && !i_pslverr) ? i_prdata : '0;
            r_status    <= i_pslverr ? STATUS_SLVERR : STATUS_OK;
            r_state     <= S_RESPONSE;
          end else if (w_expired) begin
            r_read_data <= '0;
            r_status    <= STATUS_TIMEOUT;
            r_state     <= S_RESPONSE;
          end
        end
        S_RESPONSE: begin
          if (io_rgen.response_ready) begin
            r_state <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign io_rgen.command_ready  = (r_state == S_IDLE);
  assign io_rgen.response_valid = (r_state == S_RESPONSE);
  assign io_rgen.read_data      = r_read_data;
  assign io_rgen.status         = r_status;

  assign o_psel    = (r_state == S_SETUP) || (r_state == S_ACCESS);
  assign o_penable = (r_state == S_ACCESS);
  assign o_paddr   = r_paddr;
  assign o_pwrite  = r_pwrite;
  assign o_pwdata  = r_pwdata;
  assign o_pstrb   = r_pstrb;
  assign o_pprot   = PPROT_VALUE;
endmodule
